// File: rtl/CPU_package.sv
// Shared CPU definitions used by the fetch stage and its output buffer.
// Holds the datapath widths, the fetch FSM state encoding and the entry
// type ({instruction, PC}) that travels from fetch to decode.
package CPU_package;

  localparam int DATA_WIDTH        = 32;
  localparam int ADDRESS_WIDTH     = 8;
  localparam int ADDRESS_MAX_WIDTH = 2 ** ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    data;
    logic [ADDRESS_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch_entry_t between fetch and decode.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - drop all entries; wins over push and pop in the same cycle
//   push/push_entry - write one entry at the tail
//   pop         - remove the head entry (ignored when empty)
//   head        - current head entry
//   count       - number of stored entries
//   empty       - no entries stored
module fetch_buffer
  import CPU_package::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push & ~flush;
  assign do_pop_s  = pop & ~flush & (count_q != {CW{1'b0}});

  // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == {CW{1'b0}});

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage in front of a 1-cycle-latency instruction memory.
// Owns the memory port (address_IM/we_IM/dataIM), issues sequential reads
// from pc_q while RUN, captures out_IM one cycle later and hands
// {instruction, PC} to decode through fetch_buffer (inst_valid/inst_ready).
// During LOAD the port is handed to the program loader (load_*).
// Optional performance counters are built only when FETCH_PERF_CNT_EN is
// defined; otherwise perf_fetched/perf_stall are constant 0.
// Ports: clk, rst_n, start, halt, redirect_valid/redirect_pc,
//   load_req/load_we/load_addr/load_data/load_done, address_IM, we_IM,
//   dataIM, out_IM, inst_valid, inst_ready, inst_data, inst_pc, load_busy,
//   perf_fetched, perf_stall.
module instruction_fetch
  import CPU_package::*;
#(
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = {ADDRESS_WIDTH{1'b0}},
  parameter int                       BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     load_req,
  input  logic                     load_we,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic                     load_done,
  output logic [ADDRESS_WIDTH-1:0] address_IM,
  output logic                     we_IM,
  output logic [DATA_WIDTH-1:0]    dataIM,
  input  logic [DATA_WIDTH-1:0]    out_IM,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_WIDTH-1:0]    inst_data,
  output logic [ADDRESS_WIDTH-1:0] inst_pc,
  output logic                     load_busy,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int NW = CW + 1;

  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] tag_q, tag_d;
  logic                     inflight_q, inflight_d;

  logic                     pop_s;
  logic                     flush_s;
  logic                     issue_s;
  logic                     redirect_s;
  logic                     space_s;
  logic [NW-1:0]            need_s;
  logic [CW-1:0]            count_s;
  logic                     empty_s;
  fetch_entry_t             head_s;
  fetch_entry_t             push_entry_s;

  assign pop_s      = inst_valid & inst_ready;
  assign redirect_s = redirect_valid & (state_q != LOAD);
  // Entries that will occupy the buffer once the outstanding read lands.
  assign need_s     = NW'(count_s) - NW'(pop_s) + NW'(inflight_q);
  assign space_s    = (need_s < NW'(BUF_DEPTH));

  // Next-state, PC and issue decision.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    flush_s    = 1'b0;
    issue_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d = LOAD;
          flush_s = 1'b1;
        end else if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (load_req) begin
          state_d = LOAD;
          flush_s = 1'b1;
        end else if (halt) begin
          state_d = IDLE;
          flush_s = 1'b1;
        end else if (!redirect_s && space_s) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      LOAD: begin
        if (load_done) begin
          state_d = IDLE;
          pc_d    = RESET_PC;
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        flush_s = 1'b1;
      end
    endcase
    // Redirect drops buffered entries and the read in flight.
    if (redirect_s) begin
      flush_s = 1'b1;
      pc_d    = redirect_pc;
    end else if (issue_s) begin
      pc_d       = pc_q + ADDRESS_WIDTH'(1);
      tag_d      = pc_q;
      inflight_d = 1'b1;
    end else begin
      inflight_d = 1'b0;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      tag_q      <= {ADDRESS_WIDTH{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  // Memory port mux between fetch and loader.
  always_comb begin
    if (state_q == LOAD) begin
      address_IM = load_addr;
      we_IM      = load_we;
      dataIM     = load_data;
    end else begin
      address_IM = pc_q;
      we_IM      = 1'b0;
      dataIM     = {DATA_WIDTH{1'b0}};
    end
  end

  assign push_entry_s.data = out_IM;
  assign push_entry_s.pc   = tag_q;

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .push      (inflight_q),
    .push_entry(push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s)
  );

  assign inst_valid = ~empty_s;
  assign inst_data  = head_s.data;
  assign inst_pc    = head_s.pc;
  assign load_busy  = (state_q == LOAD);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Accepted-instruction and decode-stall counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (pop_s) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if ((state_q == RUN) && inst_valid && !inst_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  assign perf_fetched = 32'd0;
  assign perf_stall   = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a 1-cycle-latency memory
// model. Inputs are driven and outputs sampled on the falling clock edge.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        load_req;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic [7:0]  address_IM;
  logic        we_IM;
  logic [31:0] dataIM;
  logic [31:0] out_IM;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic        load_busy;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  int checks;
  int errors;
  bit loaded;

  // Memory model: base pattern 0xA0+addr unless overwritten.
  bit          wr_valid [256];
  logic [31:0] wr_mem   [256];

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt          (halt),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .load_req      (load_req),
    .load_we       (load_we),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .load_done     (load_done),
    .address_IM    (address_IM),
    .we_IM         (we_IM),
    .dataIM        (dataIM),
    .out_IM        (out_IM),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .load_busy     (load_busy),
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we_IM) begin
      wr_valid[address_IM] <= 1'b1;
      wr_mem[address_IM]   <= dataIM;
    end
    out_IM <= wr_valid[address_IM] ? wr_mem[address_IM] : (32'h0000_00A0 + {24'd0, address_IM});
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] exp_data(input logic [7:0] p);
    if (loaded && p == 8'h05) return 32'h0000_DEAD;
    else if (loaded && p == 8'h06) return 32'h0000_BEEF;
    else return 32'h0000_00A0 + {24'd0, p};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next entry, checks it and lets decode accept it.
  task automatic expect_next(input logic [7:0] p);
    int w;
    w = 0;
    while (!inst_valid && w < 10) begin
      cyc();
      w++;
    end
    chk("next_valid", {31'd0, inst_valid}, 32'd1);
    chk("next_pc", {24'd0, inst_pc}, {24'd0, p});
    chk("next_data", inst_data, exp_data(p));
    cyc();
  endtask

  // Pulses start and checks the exact 2-cycle latency to the first entry.
  task automatic start_and_first(input logic [7:0] p);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("lat_c0_valid", {31'd0, inst_valid}, 32'd0);
    cyc();
    chk("lat_c1_valid", {31'd0, inst_valid}, 32'd0);
    cyc();
    chk("lat_c2_valid", {31'd0, inst_valid}, 32'd1);
    chk("lat_c2_pc", {24'd0, inst_pc}, {24'd0, p});
    chk("lat_c2_data", inst_data, exp_data(p));
    cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    loaded = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    load_req = 1'b0;
    load_we = 1'b0;
    load_addr = 8'h00;
    load_data = 32'h0;
    load_done = 1'b0;
    inst_ready = 1'b0;
    cyc();
    cyc();

    // Reset values
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", {24'd0, inst_pc}, 32'd0);
    chk("rst_busy", {31'd0, load_busy}, 32'd0);
    chk("rst_we", {31'd0, we_IM}, 32'd0);
    chk("rst_wdata", dataIM, 32'd0);
    chk("rst_addr", {24'd0, address_IM}, 32'd0);
    chk("rst_perf_f", perf_fetched, 32'd0);
    chk("rst_perf_s", perf_stall, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Start, 2-cycle latency, then one instruction per cycle
    inst_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("run_c0_valid", {31'd0, inst_valid}, 32'd0);
    cyc();
    chk("run_c1_valid", {31'd0, inst_valid}, 32'd0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("stream_valid", {31'd0, inst_valid}, 32'd1);
      chk("stream_pc", {24'd0, inst_pc}, k);
      chk("stream_data", inst_data, 32'h0000_00A0 + k);
      if (k < 3) cyc();
    end

    // Backpressure: head holds for 5 cycles, nothing lost or duplicated
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_pc", {24'd0, inst_pc}, 32'd3);
      chk("stall_data", inst_data, 32'h0000_00A3);
    end
    inst_ready = 1'b1;
    for (int k = 3; k < 8; k++) expect_next(8'(k));

    // Redirect with a valid head and a read in flight
    chk("pre_redir_valid", {31'd0, inst_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_flush", {31'd0, inst_valid}, 32'd0);
    cyc();
    chk("redir_c1_valid", {31'd0, inst_valid}, 32'd0);
    cyc();
    chk("redir_valid", {31'd0, inst_valid}, 32'd1);
    chk("redir_pc", {24'd0, inst_pc}, 32'h10);
    chk("redir_data", inst_data, 32'h0000_00B0);
    cyc();
    expect_next(8'h11);

    // Loader takes the port from RUN
    load_req = 1'b1;
    cyc();
    chk("load_busy", {31'd0, load_busy}, 32'd1);
    chk("load_flush", {31'd0, inst_valid}, 32'd0);
    load_we = 1'b1;
    load_addr = 8'h05;
    load_data = 32'h0000_DEAD;
    #1;
    chk("load_we0", {31'd0, we_IM}, 32'd1);
    chk("load_addr0", {24'd0, address_IM}, 32'h05);
    chk("load_data0", dataIM, 32'h0000_DEAD);
    cyc();
    load_addr = 8'h06;
    load_data = 32'h0000_BEEF;
    #1;
    chk("load_addr1", {24'd0, address_IM}, 32'h06);
    chk("load_data1", dataIM, 32'h0000_BEEF);
    cyc();
    load_we = 1'b0;
    #1;
    chk("load_we_off", {31'd0, we_IM}, 32'd0);
    loaded = 1'b1;
    load_req = 1'b0;
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;
    chk("done_busy", {31'd0, load_busy}, 32'd0);
    chk("done_pc", {24'd0, address_IM}, 32'h00);
    chk("done_we", {31'd0, we_IM}, 32'd0);
    start_and_first(8'h00);
    for (int k = 1; k < 7; k++) expect_next(8'(k));

    // Halt keeps pc_q and drops buffered entries
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    chk("halt_valid", {31'd0, inst_valid}, 32'd0);
    chk("halt_pc_kept", {24'd0, address_IM}, 32'h09);
    cyc();
    chk("halt_valid2", {31'd0, inst_valid}, 32'd0);

    // PC wrap from the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 8'hFF;
    cyc();
    redirect_valid = 1'b0;
    chk("idle_redir_pc", {24'd0, address_IM}, 32'hFF);
    chk("idle_redir_valid", {31'd0, inst_valid}, 32'd0);
    start_and_first(8'hFF);
    expect_next(8'h00);
    expect_next(8'h01);
    halt = 1'b1;
    cyc();
    halt = 1'b0;

    // Counters: 8 accepts and 3 stall cycles after a fresh reset
    rst_n = 1'b0;
    cyc();
    chk("rst2_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst2_addr", {24'd0, address_IM}, 32'h00);
    rst_n = 1'b1;
    cyc();
    inst_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 4; k++) expect_next(8'(k));
    inst_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    inst_ready = 1'b1;
    for (int k = 4; k < 7; k++) expect_next(8'(k));
    chk("perf_last_pc", {24'd0, inst_pc}, 32'd7);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    cyc();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'd8);
    chk("perf_stall", perf_stall, 32'd3);
`else
    chk("perf_fetched_off", perf_fetched, 32'd0);
    chk("perf_stall_off", perf_stall, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the memory's single port: drives address_IM, we_IM and dataIM.
- Consumes out_IM, which arrives one cycle after the address, and hands {instruction, PC} to decode over a valid/ready handshake through a small buffer.
- Also arbitrates the port for the program loader during LOAD.

Parameters:
- RESET_PC, 0: PC after reset and after a load completes (word address).
- BUF_DEPTH, 2: output buffer entries (power of 2, at least 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse, IDLE->RUN
- halt  in  1  pulse, RUN->IDLE
- redirect_valid  in  1  branch/jump redirect
- redirect_pc  in  ADDRESS_WIDTH  redirect target
- load_req  in  1  loader requests the memory port
- load_we  in  1  loader write strobe
- load_addr  in  ADDRESS_WIDTH  loader address
- load_data  in  DATA_WIDTH  loader data
- load_done  in  1  pulse, LOAD->IDLE
- address_IM  out  ADDRESS_WIDTH  to memory address
- we_IM  out  1  to memory write enable
- dataIM  out  DATA_WIDTH  to memory write data
- out_IM  in  DATA_WIDTH  memory read data (1-cycle latency)
- inst_valid  out  1  instruction available
- inst_ready  in  1  decode accepts
- inst_data  out  DATA_WIDTH  instruction
- inst_pc  out  ADDRESS_WIDTH  PC of inst_data
- load_busy  out  1  high in LOAD
- perf_fetched  out  32  accepted instructions (macro-gated)
- perf_stall  out  32  stall cycles (macro-gated)

Behaviour:
- Reset values: state=IDLE, pc_q=RESET_PC, buffer empty, inflight=0, we_IM=0, dataIM=0, inst_valid=0, inst_data=0, inst_pc=0, load_busy=0, perf counters=0.
- Port mux:
  - In LOAD: address_IM=load_addr, we_IM=load_we, dataIM=load_data.
  - Otherwise: address_IM=pc_q, we_IM=0, dataIM=0.
- States:
  - IDLE: start->RUN; load_req->LOAD.
  - RUN: halt->IDLE; load_req->LOAD; load_req has priority over halt.
  - LOAD: load_done->IDLE, and pc_q<=RESET_PC.
- Issue (RUN only):
  - Condition: occupancy_after_pop + inflight < BUF_DEPTH, where occupancy_after_pop = count - (inst_valid & inst_ready).
  - On issue: inflight<=1, tag_q<=pc_q, pc_q<=pc_q+1.
  - pc_q wraps modulo 2^ADDRESS_WIDTH.
- Capture: when inflight=1, push {out_IM, tag_q} into the buffer on that cycle. Push and pop in the same cycle are allowed.
- Output: inst_valid = buffer not empty; inst_data/inst_pc show the head entry. Head stays stable while inst_valid=1 and inst_ready=0.
- Throughput and latency:
  - Steady state with inst_ready=1: one instruction per cycle.
  - First inst_valid arrives 2 cycles after RUN entry (issue cycle, then capture cycle).
- Redirect (any state except LOAD, highest priority):
  - Flush the buffer, clear inflight (the next out_IM is discarded), pc_q<=redirect_pc.
  - A simultaneous pop is ignored.
  - In RUN, no issue in the redirect cycle; issue from redirect_pc on the next cycle.
  - In IDLE, only pc_q is updated.
  - In LOAD, redirect is ignored.
- Entering LOAD or IDLE via halt: flush the buffer, clear inflight, inst_valid drops the next cycle. pc_q is kept on halt.
- start while already in RUN, or load_done outside LOAD: ignored.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - perf_fetched increments on each inst_valid&inst_ready.
  - perf_stall increments on each RUN cycle with inst_valid&!inst_ready.
  - Both counters wrap at 2^32 and are cleared only by reset.
- When undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package CPU_package holds DATA_WIDTH, ADDRESS_WIDTH, ADDRESS_MAX_WIDTH, plus the new fetch_state_t enum {IDLE, RUN, LOAD} and the fetch_entry_t struct {data, pc}.
- One sub-module: fetch_buffer, a synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and head output.

Test Plan:
- Reset, then start with inst_ready=1 and mem[0..3]=A0,A1,A2,A3 -> inst_valid rises 2 cycles after start; (A0,0),(A1,1),(A2,2),(A3,3) are delivered on consecutive cycles.
- inst_ready=0 for 5 cycles mid-stream -> inst_data/inst_pc hold; no more than BUF_DEPTH entries are buffered; no instruction is lost or duplicated after release.
- redirect_valid with redirect_pc=0x10 while inst_valid=1 and inflight=1 -> buffer flushed; the next delivered entry is (mem[0x10], 0x10); the discarded out_IM never appears.
- load_req in RUN with writes 0xDEAD to address 5 and 0xBEEF to address 6, then load_done and start -> we_IM follows load_we during LOAD; fetch restarts at RESET_PC; addresses 5 and 6 return 0xDEAD and 0xBEEF.
- pc_q=2^ADDRESS_WIDTH-1 during RUN -> next inst_pc is 0 (wrap).
- With FETCH_PERF_CNT_EN: 8 accepts and 3 stall cycles -> perf_fetched=8, perf_stall=3. Without the macro -> both ports read 0.
